pixel_stage_buffer: RTL

// Per-lane FIFO between one rasterizer and one lane of the depth comparator. Absorbs

---
 rtl/pixel_stage_buffer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/pixel_stage_buffer.sv
// -----------------------------------------------------------------------------
// pixel_stage_buffer
//
// Per-lane FIFO between one rasterizer and one lane of the depth comparator.
// It absorbs fragment bursts so the rasterizer does not stall while the
// comparator serves other lanes. The head entry is offered to the comparator
// and retired only when the comparator signals completion on `written`.
//
// Comparator handshake on the head entry:
//   - `written` seen low while an entry is offered -> entry is "taken"
//     (head frozen from then on).
//   - `written` seen high while taken -> entry done, head popped.
//   - After a pop the comparator must drop `written` again for the next entry.
//
// in_data / out_data packing (pixel_info_t flattened, DATA_W = 64):
//   [63:48] x   [47:32] y   [31:16] depth   [15:0] color
// The FIFO never looks inside the entry; the packing only matters to the
// rasterizer and comparator.
//
// Ports
//   clock     in   1        system clock, all logic on posedge
//   reset     in   1        synchronous, active-high
//   in_data   in   DATA_W   fragment from rasterizer
//   in_valid  in   1        rasterizer offers in_data this cycle
//   in_ready  out  1        FIFO accepts (push = in_valid && in_ready)
//   out_data  out  DATA_W   head entry ('0 when nothing is offered)
//   out_valid out  1        head entry present
//   written   in   1        comparator completion: 0 = taken, 0->1 = done
//   flush     in   1        drop all untaken entries (frame abort)
//   count     out  CNT_W    current occupancy
//   empty     out  1        nothing stored and nothing pending
// -----------------------------------------------------------------------------
module pixel_stage_buffer #(
  parameter int  DEPTH  = 8,
  parameter int  DATA_W = 64,
  localparam int CNT_W  = $clog2(DEPTH) + 1,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              written,
  input  logic              flush,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              taken;      // head handed to the comparator, not yet done
  logic              written_q;  // previous-cycle written, to see the 0->1 edge

  logic [ADDR_W-1:0] rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_d;
  logic [CNT_W-1:0]  count_d;
  logic              taken_d;

  logic push_en;
  logic pop_en;
  logic take_en;

  // ---------------------------------------------------------------------------
  // Outputs: all derived from registered state only. Neither `written` nor
  // `in_valid` reaches an output combinationally.
  // ---------------------------------------------------------------------------
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign count     = count_q;
  // A taken entry is still counted in count_q, so count==0 already implies
  // nothing is pending at the comparator.
  assign empty     = (count_q == '0);

  // ---------------------------------------------------------------------------
  // Events
  // ---------------------------------------------------------------------------
  // Full blocks a push even when a pop happens the same cycle: in_ready is a
  // function of the registered count only. Flush discards a coincident push.
  assign push_en = in_valid && in_ready && !flush;

  // Pop only from the taken state on the rising edge of written. Because
  // taken is entered on a cycle where written was low, written_q is always
  // low on the first high cycle afterwards; a written held high never pops.
  assign pop_en  = taken && written && !written_q;

  // Offer accepted: comparator drops written while a head is visible.
  // Flush wins, so an untaken head being flushed is never taken.
  assign take_en = !taken && out_valid && !written && !flush;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    rd_ptr_d = rd_ptr;
    wr_ptr_d = wr_ptr;
    count_d  = count_q;
    taken_d  = taken;

    if (flush) begin
      if (pop_en) begin
        // Head completes in the flush cycle: nothing survives.
        rd_ptr_d = rd_ptr + ADDR_W'(1);
        wr_ptr_d = rd_ptr + ADDR_W'(1);
        count_d  = '0;
        taken_d  = 1'b0;
      end else if (taken) begin
        // Comparator owns the head: keep it alone, drop everything behind it.
        wr_ptr_d = rd_ptr + ADDR_W'(1);
        count_d  = CNT_W'(1);
      end else begin
        rd_ptr_d = wr_ptr;
        count_d  = '0;
      end
    end else begin
      if (push_en) begin
        wr_ptr_d = wr_ptr + ADDR_W'(1);
      end

      if (pop_en) begin
        rd_ptr_d = rd_ptr + ADDR_W'(1);
        taken_d  = 1'b0;
      end else if (take_en) begin
        taken_d  = 1'b1;
      end

      unique case ({push_en, pop_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count_q   <= '0;
      taken     <= 1'b0;
      written_q <= 1'b1;
    end else begin
      rd_ptr    <= rd_ptr_d;
      wr_ptr    <= wr_ptr_d;
      count_q   <= count_d;
      taken     <= taken_d;
      written_q <= written;
    end
  end

  // NOTE: the storage array has no reset; stale contents are never visible
  // because out_data is masked by out_valid and count bounds every read.
  always_ff @(posedge clock) begin
    if (push_en) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Properties
  // ---------------------------------------------------------------------------
  // A push never lands on the head slot while entries are stored, so the
  // head stays put for as long as the comparator holds it.
  a_head_frozen: assert property (
    @(posedge clock) disable iff (reset)
      (taken && !pop_en) |=> $stable(out_data)
  );

  a_count_bound: assert property (
    @(posedge clock) disable iff (reset)
      count_q <= CNT_W'(DEPTH)
  );

  a_taken_has_head: assert property (
    @(posedge clock) disable iff (reset)
      taken |-> out_valid
  );

endmodule
